ibex_ex_seq: RTL and testbench

- ID-side companion of the execution stage. It issues instructions into EX and drives the EX dynamic enables.
- It owns the intermediate value registers that EX writes via its imd_val write-enable and data outputs.
- It consumes EX's valid and saturation outputs.
- It tracks single- and multi-cycle ALU/MULT/DIV/Pext operations, holds results until writeback accepts them, accumulates the sticky vxsat flag, and reports per-instruction EX occupancy.

---
 rtl/ibex_ex_seq.sv | 148 ++++++++++++++
 tb/tb_ibex_ex_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_ex_seq.sv
// Purpose: ID-side EX sequencer; issues into EX, owns the imd registers, tracks multi-cycle ops and sticky vxsat.
// Latency: single-cycle ops retire in the issue cycle; multi-cycle ops retire on the cycle EX is valid and WB is ready.
// Backpressure: wb_ready_i low parks a valid result in WAIT_WB and holds stall_o; flush_i drops the instruction at once.
module ibex_ex_seq #(
  parameter int unsigned ImdWidth = 34,
  parameter int unsigned CntWidth = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_valid_i,
  input  logic                     mult_sel_i,
  input  logic                     div_sel_i,
  input  logic                     flush_i,
  input  logic                     wb_ready_i,
  input  logic                     ex_valid_i,
  input  logic [1:0]               imd_val_we_i,
  input  logic [1:0][ImdWidth-1:0] imd_val_d_i,
  input  logic                     vxsat_set_i,
  input  logic                     vxsat_we_i,
  input  logic                     vxsat_wdata_i,
  output logic [1:0][ImdWidth-1:0] imd_val_q_o,
  output logic                     mult_en_o,
  output logic                     div_en_o,
  output logic                     alu_instr_first_cycle_o,
  output logic                     multdiv_ready_id_o,
  output logic                     instr_done_o,
  output logic                     stall_o,
  output logic                     vxsat_o,
  output logic [CntWidth-1:0]      ex_cycles_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MULTI   = 2'd1,
    WAIT_WB = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       mult_q, div_q;
  logic [CntWidth-1:0]        cnt_q, cnt_d;
  logic                       vxsat_q, vxsat_d;
  logic [1:0][ImdWidth-1:0]   imd_q;
  logic                       issue;
  logic                       busy;
  logic [1:0]                 imd_wr;

  assign issue = (state_q == IDLE) & instr_valid_i & ~flush_i;
  assign busy  = (state_q != IDLE) | instr_valid_i;

  // EX only owns the imd registers while the instruction is executing, never while parked for WB
  assign imd_wr = imd_val_we_i & {2{issue | ((state_q == MULTI) & ~flush_i)}};

  // Next-state, EX enables, retirement and occupancy counter
  always_comb begin
    state_d                 = state_q;
    cnt_d                   = cnt_q;
    mult_en_o               = 1'b0;
    div_en_o                = 1'b0;
    alu_instr_first_cycle_o = 1'b0;
    instr_done_o            = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue) begin
          alu_instr_first_cycle_o = 1'b1;
          mult_en_o               = mult_sel_i;
          div_en_o                = div_sel_i;
          if (ex_valid_i) begin
            if (wb_ready_i) instr_done_o = 1'b1;
            else            state_d      = WAIT_WB;
          end else begin
            state_d = MULTI;
          end
        end
      end
      MULTI: begin
        mult_en_o = mult_q;
        div_en_o  = div_q;
        if (ex_valid_i) begin
          if (wb_ready_i) begin
            instr_done_o = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = WAIT_WB;
          end
        end
      end
      WAIT_WB: begin
        mult_en_o = mult_q;
        div_en_o  = div_q;
        if (wb_ready_i) begin
          instr_done_o = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d      = IDLE;
      mult_en_o    = 1'b0;
      div_en_o     = 1'b0;
      instr_done_o = 1'b0;
    end

    // Count only cycles that are followed by another EX cycle, so the final value is the extra latency
    if (flush_i) begin
      cnt_d = '0;
    end else if (issue) begin
      cnt_d = (state_d != IDLE) ? CntWidth'(1) : '0;
    end else if ((state_q != IDLE) && (state_d != IDLE) && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  // CSR write takes effect first; a retiring saturating result always wins over a clear
  assign vxsat_d = (vxsat_we_i ? vxsat_wdata_i : vxsat_q) | (instr_done_o & vxsat_set_i);

  // State, latched enables, counter, vxsat and intermediate value registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mult_q  <= 1'b0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
      vxsat_q <= 1'b0;
      imd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vxsat_q <= vxsat_d;
      if (issue) begin
        mult_q <= mult_sel_i;
        div_q  <= div_sel_i;
      end
      for (int k = 0; k < 2; k++) begin
        if (imd_wr[k]) imd_q[k] <= imd_val_d_i[k];
      end
    end
  end

  assign multdiv_ready_id_o = wb_ready_i & busy;
  assign stall_o            = busy & ~instr_done_o & ~flush_i;
  assign vxsat_o            = vxsat_q;
  assign ex_cycles_o        = cnt_q;
  assign imd_val_q_o        = imd_q;

endmodule

// File: tb/tb_ibex_ex_seq.sv
// Directed bench for ibex_ex_seq: single-cycle, divide, backpressure, flush, vxsat, counter saturation, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later, well clear of the edge.
// All expected values are hand-derived constants or simple arithmetic on the stimulus.
module tb_ibex_ex_seq;

  localparam int unsigned ImdWidth = 34;
  localparam int unsigned CntWidth = 6;

  logic                     clk;
  logic                     rst;
  logic                     instr_valid, mult_sel, div_sel, flush, wb_ready, ex_valid;
  logic [1:0]               imd_we;
  logic [1:0][ImdWidth-1:0] imd_d;
  logic                     vxsat_set, vxsat_we, vxsat_wdata;
  logic [1:0][ImdWidth-1:0] imd_q;
  logic                     mult_en, div_en, first_cycle, md_ready, done, stall, vxsat;
  logic [CntWidth-1:0]      ex_cycles;

  int errors = 0;
  int checks = 0;

  localparam logic [ImdWidth-1:0] DatA = 34'h3_0000_0001;
  localparam logic [ImdWidth-1:0] DatB = 34'h0_DEAD_BEEF;

  ibex_ex_seq #(.ImdWidth(ImdWidth), .CntWidth(CntWidth)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .instr_valid_i           (instr_valid),
    .mult_sel_i              (mult_sel),
    .div_sel_i               (div_sel),
    .flush_i                 (flush),
    .wb_ready_i              (wb_ready),
    .ex_valid_i              (ex_valid),
    .imd_val_we_i            (imd_we),
    .imd_val_d_i             (imd_d),
    .vxsat_set_i             (vxsat_set),
    .vxsat_we_i              (vxsat_we),
    .vxsat_wdata_i           (vxsat_wdata),
    .imd_val_q_o             (imd_q),
    .mult_en_o               (mult_en),
    .div_en_o                (div_en),
    .alu_instr_first_cycle_o (first_cycle),
    .multdiv_ready_id_o      (md_ready),
    .instr_done_o            (done),
    .stall_o                 (stall),
    .vxsat_o                 (vxsat),
    .ex_cycles_o             (ex_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    instr_valid = 1'b0; mult_sel = 1'b0; div_sel = 1'b0; flush = 1'b0;
    wb_ready = 1'b0; ex_valid = 1'b0; imd_we = 2'b00; imd_d = '0;
    vxsat_set = 1'b0; vxsat_we = 1'b0; vxsat_wdata = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    // Reset state, IDLE with no instruction: everything low
    chk("rst_imd", imd_q, '0);
    chk("rst_vxsat", vxsat, 1'b0);
    chk("rst_cnt", ex_cycles, 0);
    chk("rst_comb", {mult_en, div_en, first_cycle, md_ready, done, stall}, 6'b0);

    // Single-cycle ALU op retires in its issue cycle
    cyc();
    instr_valid = 1'b1; ex_valid = 1'b1; wb_ready = 1'b1;
    #1;
    chk("alu_done", done, 1'b1);
    chk("alu_stall", stall, 1'b0);
    chk("alu_first", first_cycle, 1'b1);
    chk("alu_ready", md_ready, 1'b1);
    cyc();
    clr();
    #1;
    chk("alu_idle", {stall, done, mult_en, div_en}, 4'b0);
    chk("alu_cnt", ex_cycles, 0);

    // Divide, 37 EX cycles, both imd entries written every cycle
    for (int i = 1; i <= 37; i++) begin
      if (i > 1) cyc();
      instr_valid = 1'b1; div_sel = 1'b1; wb_ready = 1'b1;
      ex_valid = (i == 37);
      imd_we   = 2'b11;
      imd_d[0] = DatA + ImdWidth'(i);
      imd_d[1] = DatB + ImdWidth'(i);
      #1;
      chk("div_en", div_en, 1'b1);
      chk("div_done", done, (i == 37));
      chk("div_first", first_cycle, (i == 1));
      chk("div_stall", stall, (i != 37));
      if (i > 1) begin
        chk("div_imd0", imd_q[0], DatA + ImdWidth'(i - 1));
        chk("div_imd1", imd_q[1], DatB + ImdWidth'(i - 1));
      end
    end
    cyc();
    clr();
    #1;
    chk("div_imd0_last", imd_q[0], DatA + ImdWidth'(37));
    chk("div_imd1_last", imd_q[1], DatB + ImdWidth'(37));
    chk("div_cnt", ex_cycles, 36);
    chk("div_idle", {stall, div_en}, 2'b00);

    // Multiply valid on cycle 3, writeback stalled until cycle 7
    for (int c = 1; c <= 7; c++) begin
      cyc();
      clr();
      instr_valid = 1'b1; mult_sel = 1'b1;
      ex_valid = (c == 3);
      wb_ready = (c == 7);
      if (c >= 4 && c <= 6) begin
        imd_we   = 2'b10;
        imd_d[1] = 34'h2_5555_AAAA;
      end
      #1;
      chk("bp_mult_en", mult_en, 1'b1);
      chk("bp_done", done, (c == 7));
      chk("bp_ready", md_ready, (c == 7));
      chk("bp_stall", stall, (c != 7));
    end
    cyc();
    clr();
    #1;
    chk("bp_imd1_kept", imd_q[1], DatB + ImdWidth'(37));
    chk("bp_cnt", ex_cycles, 6);

    // Divide flushed in its 5th cycle while EX writes entry 0
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) cyc();
      clr();
      instr_valid = 1'b1; div_sel = 1'b1;
      if (c == 5) begin
        flush    = 1'b1;
        imd_we   = 2'b01;
        imd_d[0] = 34'h1_2345_6789;
      end
      #1;
      if (c == 4) chk("fl_cnt_pre", ex_cycles, 3);
      if (c == 5) begin
        chk("fl_cnt_mid", ex_cycles, 4);
        chk("fl_en", {div_en, mult_en}, 2'b00);
        chk("fl_done", done, 1'b0);
        chk("fl_stall", stall, 1'b0);
      end
    end
    cyc();
    clr();
    #1;
    chk("fl_imd0", imd_q[0], DatA + ImdWidth'(37));
    chk("fl_cnt", ex_cycles, 0);
    chk("fl_idle", {stall, div_en, first_cycle}, 3'b000);

    // vxsat: set, clear-vs-set race, plain clear, flushed and stalled results
    instr_valid = 1'b1; ex_valid = 1'b1; wb_ready = 1'b1; vxsat_set = 1'b1;
    cyc();
    #1;
    chk("vx_set", vxsat, 1'b1);
    vxsat_we = 1'b1; vxsat_wdata = 1'b0;
    cyc();
    #1;
    chk("vx_race", vxsat, 1'b1);
    clr();
    vxsat_we = 1'b1;
    cyc();
    #1;
    chk("vx_clear", vxsat, 1'b0);
    clr();
    instr_valid = 1'b1; ex_valid = 1'b1; wb_ready = 1'b1; vxsat_set = 1'b1; flush = 1'b1;
    #1;
    chk("vx_flush_done", done, 1'b0);
    cyc();
    #1;
    chk("vx_flush", vxsat, 1'b0);
    clr();
    instr_valid = 1'b1; ex_valid = 1'b1; vxsat_set = 1'b1;
    cyc();
    #1;
    chk("vx_stalled", vxsat, 1'b0);
    clr();
    wb_ready = 1'b1;
    #1;
    chk("vx_wb_done", done, 1'b1);
    cyc();
    clr();
    #1;
    chk("vx_after_wb", vxsat, 1'b0);

    // Occupancy counter saturates on an 81-cycle instruction
    for (int c = 1; c <= 81; c++) begin
      instr_valid = 1'b1; div_sel = 1'b1;
      ex_valid = (c == 81); wb_ready = (c == 81);
      #1;
      if (c == 81) chk("sat_done", done, 1'b1);
      cyc();
    end
    clr();
    #1;
    chk("sat_cnt", ex_cycles, 63);

    // Reset in the middle of a multiply
    instr_valid = 1'b1; ex_valid = 1'b1; wb_ready = 1'b1; vxsat_set = 1'b1;
    cyc();
    clr();
    #1;
    chk("rs_vx_pre", vxsat, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      instr_valid = 1'b1; mult_sel = 1'b1; imd_we = 2'b11;
      imd_d[0] = 34'h0_0000_00C1; imd_d[1] = 34'h0_0000_00D2;
      cyc();
    end
    clr();
    #1;
    chk("rs_imd_pre", imd_q[0], 34'h0_0000_00C1);
    chk("rs_busy_pre", {stall, mult_en}, 2'b11);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rs_imd", imd_q, '0);
    chk("rs_vx", vxsat, 1'b0);
    chk("rs_cnt", ex_cycles, 0);
    chk("rs_idle", {done, stall, mult_en, md_ready}, 4'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
